// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator / monitor pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DRAIN = 2'd3
  } pulse_state_t;

  localparam int PULSE_CNT_W        = 32;
  localparam int PULSE_WIDTH_W      = 16;
  localparam int PULSE_IDLE_TIMEOUT = 16;

  // Bits needed for a counter that must be able to hold the value 'timeout'.
  function automatic int idle_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// Registers the pulse line and flags its rising and falling edges.
// Latency: rise/fall are combinational against the 1-cycle delayed copy.
// Backpressure: none; pulse is sampled every cycle.
module pulse_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic pulse,
  output logic rise,
  output logic fall
);

  logic pulseQ;

  // Delayed copy of the pulse line; cleared on reset so a high line counts as an edge.
  always_ff @(posedge clk) begin
    if (reset) pulseQ <= 1'b0;
    else       pulseQ <= pulse;
  end

  assign rise = pulse & ~pulseQ;
  assign fall = ~pulse & pulseQ;

endmodule

// File: rtl/pulse_monitor.sv
// Counts pulse rising edges against a programmed minimum, raises waitOnMe, reports end of train.
// Latency: 1 cycle from a rising edge to pulseTotal/waitOnMe; complete IDLE_TIMEOUT cycles after last edge.
// Backpressure: none; optional width measurement enabled by defining PULSE_MONITOR_WIDTH_EN.
module pulse_monitor
  import pulse_pkg::*;
#(
  parameter int CNT_W        = PULSE_CNT_W,
  parameter int IDLE_TIMEOUT = PULSE_IDLE_TIMEOUT,  // must be >= 2
  parameter int WIDTH_W      = PULSE_WIDTH_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic [CNT_W-1:0]   expectCount,
  input  logic               pulse,
  output logic               waitOnMe,
  output logic               busy,
  output logic               complete,
  output logic               timeoutErr,
  output logic [CNT_W-1:0]   pulseTotal,
  output logic [WIDTH_W-1:0] minWidth,
  output logic [WIDTH_W-1:0] maxWidth
);

  localparam int IW = idle_cnt_w(IDLE_TIMEOUT);
  localparam logic [IW-1:0]    IDLE_LIM = IW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0]    IDLE_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  pulse_state_t     state, state_nxt;
  logic [CNT_W-1:0] expect_lat, expect_nxt;
  logic [CNT_W-1:0] total_nxt, inc_total;
  logic [IW-1:0]    idle_cnt, idle_nxt, idle_inc;
  logic             idle_hit;
  logic             wait_nxt, terr_nxt, cmpl_nxt;
  logic             rise, fall;

  pulse_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .pulse (pulse),
    .rise  (rise),
    .fall  (fall)
  );

  assign busy = (state != IDLE);

  // State and measurement registers; everything clears on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      expect_lat <= '0;
      pulseTotal <= '0;
      idle_cnt   <= '0;
      waitOnMe   <= 1'b0;
      timeoutErr <= 1'b0;
      complete   <= 1'b0;
    end else begin
      state      <= state_nxt;
      expect_lat <= expect_nxt;
      pulseTotal <= total_nxt;
      idle_cnt   <= idle_nxt;
      waitOnMe   <= wait_nxt;
      timeoutErr <= terr_nxt;
      complete   <= cmpl_nxt;
    end
  end

  // Next-state logic: arm restarts from any state; the idle counter counts cycles without a rise.
  always_comb begin
    state_nxt  = state;
    expect_nxt = expect_lat;
    total_nxt  = pulseTotal;
    idle_nxt   = idle_cnt;
    wait_nxt   = waitOnMe;
    terr_nxt   = timeoutErr;
    cmpl_nxt   = 1'b0;
    inc_total  = (pulseTotal == '1) ? pulseTotal : pulseTotal + CNT_ONE;
    idle_inc   = (idle_cnt == IDLE_LIM) ? idle_cnt : idle_cnt + IDLE_ONE;
    idle_hit   = (idle_inc == IDLE_LIM);

    if (arm) begin
      // A rise coinciding with arm is deliberately not counted.
      expect_nxt = expectCount;
      total_nxt  = '0;
      idle_nxt   = '0;
      terr_nxt   = 1'b0;
      if (expectCount == '0) begin
        wait_nxt  = 1'b1;
        state_nxt = DRAIN;
      end else begin
        wait_nxt  = 1'b0;
        state_nxt = ARMED;
      end
    end else begin
      case (state)
        ARMED, COUNT: begin
          if (rise) begin
            total_nxt = inc_total;
            idle_nxt  = '0;
            state_nxt = COUNT;
            if (inc_total == expect_lat) begin
              wait_nxt  = 1'b1;
              state_nxt = DRAIN;
            end
          end else if (idle_hit) begin
            terr_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idle_nxt = idle_inc;
          end
        end
        DRAIN: begin
          // Late pulses still count; a stuck-high line defers completion until it drops.
          if (rise) begin
            total_nxt = inc_total;
            idle_nxt  = '0;
          end else if (idle_hit && !pulse) begin
            cmpl_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idle_nxt = idle_inc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PULSE_MONITOR_WIDTH_EN
  localparam logic [WIDTH_W-1:0] W_ONE = 1;
  logic [WIDTH_W-1:0] high_cnt;

  // High-time counter; min/max are captured on each falling edge and cleared by arm.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_cnt <= '0;
      minWidth <= '1;
      maxWidth <= '0;
    end else begin
      if (pulse) high_cnt <= (high_cnt == '1) ? high_cnt : high_cnt + W_ONE;
      else       high_cnt <= '0;
      if (arm) begin
        minWidth <= '1;
        maxWidth <= '0;
      end else if (fall) begin
        if (high_cnt < minWidth) minWidth <= high_cnt;
        if (high_cnt > maxWidth) maxWidth <= high_cnt;
      end
    end
  end
`else
  logic unused_fall;
  assign unused_fall = fall;
  assign minWidth    = '1;
  assign maxWidth    = '0;
`endif

endmodule
